fifo_status_prog: RTL and testbench
===================================

# fifo_status_prog

Synchronous single-clock FIFO with full and empty status, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and an occupancy count. It is the parametrised successor to the fixed-status FIFO in the memory design examples. It sits between a producer and a consumer in the same clock domain. A compile-time macro selects between a standard registered read and first-word-fall-through (FWFT) read behaviour.

## Interface
- DATA_WIDTH, 32, width of each stored word
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset; synchronous, active-high
- wr  input  1  write request
- wr_data  input  DATA_WIDTH  write word
- rd  input  1  read/pop request
- rd_data  output  DATA_WIDTH  read word
- rd_valid  output  1  rd_data holds a valid word
- full, empty  output  1  count == DEPTH, count == 0
- almost_full  output  1  count >= af_level
- almost_empty  output  1  count <= ae_level
- af_level, ae_level  input  ADDR_WIDTH+1  threshold values; sampled every cycle
- w_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  output  1  sticky error flags
- err_clr  input  1  clears the sticky flags

## Operation
- Write is accepted when wr && !full. The word is stored at wr_ptr and wr_ptr increments.
- Read is accepted when rd && !empty. rd_ptr increments.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- w_count changes by +1 on an accepted write only and by -1 on an accepted read only. It is unchanged when both or neither are accepted.
- Write while full is dropped: storage and pointers are unchanged and overflow is set. This holds even if rd is accepted in the same cycle.
- Read while empty is ignored and underflow is set. This holds even if wr is accepted in the same cycle; the written word is stored normally.
- When both are accepted and the FIFO is neither full nor empty, both pointers advance and w_count is unchanged.
- overflow and underflow stay set until err_clr. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Status flags are derived combinationally from the registered w_count and the live af_level/ae_level.
- af_level = 0 forces almost_full = 1. ae_level >= DEPTH forces almost_empty = 1.

## Timing
- Reset values:
  - w_count 0, pointers 0
  - empty 1, full 0, almost_empty 1
  - almost_full 0 (1 only if af_level = 0)
  - rd_data 0, rd_valid 0 (standard mode)
  - overflow 0, underflow 0
- Storage contents are not reset.
- Reset asserted mid-operation discards all contents on that edge. Requests in the reset cycle are ignored and set no error flags.
- Status and w_count update on the edge of the accepted transfer and are visible the following cycle.
- Minimum write-to-readable latency: empty deasserts 1 cycle after the accepting edge.

## Configuration
- FIFO_STATUS_FWFT_EN defined (FWFT mode):
  - rd_data = mem[rd_ptr] combinationally whenever !empty, so the head word is visible with no read request.
  - rd_valid = !empty. rd acts as pop/acknowledge.
  - rd_data is don't-care while empty.
- FIFO_STATUS_FWFT_EN undefined (standard mode):
  - rd_data is registered and loaded with mem[rd_ptr] on an accepted read.
  - rd_valid pulses 1 on the cycle after each accepted read, giving 1-cycle read latency.
  - rd_data holds its last value otherwise.

## Structure
- Package fifo_status_pkg holds:
  - a count_t typedef sized from ADDR_WIDTH+1 via a parameterised helper function
  - the error-flag enum (ERR_NONE, ERR_OVF, ERR_UDF) used by the bench monitor
- One sub-module, fifo_status_ctrl: pointers, w_count, accept logic, status flags and sticky error flags.
- The top level holds the storage array and the read-data path, including the FWFT mux.

## Test plan
- Fill then drain: after reset, write 16 words 0x1..0x10, then pop 16.
  - full = 1 and w_count = 16 after the 16th write.
  - Data is returned in order 0x1..0x10; empty = 1 at the end.
  - overflow = 0 and underflow = 0 throughout.
- Overflow: with the FIFO full, write 0xDEAD with rd = 1 in the same cycle.
  - The write is dropped, overflow = 1 and w_count = 15.
  - 0xDEAD never appears on rd_data.
  - err_clr then clears overflow.
- Underflow: with the FIFO empty, assert wr = 1 (0x55) and rd = 1 together.
  - underflow = 1 and w_count = 1.
  - The next pop returns 0x55.
- Thresholds: set af_level = 12 and ae_level = 3 and step w_count 0→16.
  - almost_empty = 1 for counts 0..3.
  - almost_full = 1 for counts 12..16.
  - Changing af_level to 14 at count 13 deasserts almost_full in the same cycle.
- Wrap and concurrency: run 40 cycles of continuous write and read at count 8.
  - Pointers wrap at least twice and w_count stays at 8.
  - Data matches the scoreboard; run in both FWFT and standard builds.
- Reset mid-stream: assert rst at count 9 with wr = 1.
  - Next cycle: w_count = 0, empty = 1, rd_valid = 0.
  - No error flags are set.

Source files
------------

// File: rtl/fifo_status_pkg.sv
// Shared types for the programmable-status FIFO: occupancy width helper,
// default count type and the error-flag encoding used when observing the flags.
package fifo_status_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Occupancy runs 0..2**addr_width inclusive, so it needs one extra bit.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  typedef logic [count_width(DEF_ADDR_WIDTH)-1:0] count_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } err_e;

endpackage

// File: rtl/fifo_status_ctrl.sv
// FIFO control: pointers, occupancy count, accept logic, threshold status
// and sticky overflow/underflow flags. Storage lives in the parent.
module fifo_status_ctrl
  import fifo_status_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_wr,
  input  logic                                  i_rd,
  input  logic                                  i_err_clr,
  input  logic [count_width(ADDR_WIDTH)-1:0]    i_af_level,
  input  logic [count_width(ADDR_WIDTH)-1:0]    i_ae_level,
  output logic                                  o_wr_en,
  output logic                                  o_rd_en,
  output logic [ADDR_WIDTH-1:0]                 o_wr_addr,
  output logic [ADDR_WIDTH-1:0]                 o_rd_addr,
  output logic [count_width(ADDR_WIDTH)-1:0]    o_count,
  output logic                                  o_full,
  output logic                                  o_empty,
  output logic                                  o_almost_full,
  output logic                                  o_almost_empty,
  output logic                                  o_overflow,
  output logic                                  o_underflow
);

  localparam int unsigned    CW    = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0]  DEPTH = CW'(2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = i_wr && !w_full;
  assign w_rd_ok = i_rd && !w_empty;

  // NOTE: reset is synchronous, so it is simply the highest-priority branch
  // of the clocked block; requests in the reset cycle never reach the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);

      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // NOTE: a new error outranks err_clr so a same-cycle event is never lost.
      if (i_wr && w_full)      r_overflow <= 1'b1;
      else if (i_err_clr)      r_overflow <= 1'b0;

      if (i_rd && w_empty)     r_underflow <= 1'b1;
      else if (i_err_clr)      r_underflow <= 1'b0;
    end
  end

  assign o_wr_en        = w_wr_ok && !rst;
  assign o_rd_en        = w_rd_ok && !rst;
  assign o_wr_addr      = r_wr_ptr;
  assign o_rd_addr      = r_rd_ptr;
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (i_af_level == '0)   || (r_count >= i_af_level);
  assign o_almost_empty = (i_ae_level >= DEPTH) || (r_count <= i_ae_level);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: rtl/fifo_status_prog.sv
// Single-clock FIFO with programmable status. Define FIFO_STATUS_FWFT_EN for
// first-word-fall-through reads; otherwise reads are registered (1-cycle latency).
module fifo_status_prog
  import fifo_status_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  input  logic [count_width(ADDR_WIDTH)-1:0] af_level,
  input  logic [count_width(ADDR_WIDTH)-1:0] ae_level,
  output logic [count_width(ADDR_WIDTH)-1:0] w_count,
  output logic                               overflow,
  output logic                               underflow,
  input  logic                               err_clr
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  fifo_status_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .i_wr           (wr),
    .i_rd           (rd),
    .i_err_clr      (err_clr),
    .i_af_level     (af_level),
    .i_ae_level     (ae_level),
    .o_wr_en        (w_wr_en),
    .o_rd_en        (w_rd_en),
    .o_wr_addr      (w_wr_addr),
    .o_rd_addr      (w_rd_addr),
    .o_count        (w_count),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  // NOTE: storage has no reset; the pointers and count define what is valid,
  // which keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= wr_data;
  end

`ifdef FIFO_STATUS_FWFT_EN
  // The head word is always presented; rd only acknowledges it.
  logic w_unused_rd_en;
  assign w_unused_rd_en = w_rd_en;
  assign rd_data        = r_mem[w_rd_addr];
  assign rd_valid       = !empty;
`else
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_fifo_status_prog.sv
// Scoreboard bench for fifo_status_prog: stimulus pushes expected read words,
// a negedge monitor pops and compares them and checks status against a model.
module tb_fifo_status_prog;
  import fifo_status_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] wr_data;
  logic        rd;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  count_t      af_level;
  count_t      ae_level;
  count_t      w_count;
  logic        overflow;
  logic        underflow;
  logic        err_clr;

  always #5 clk = ~clk;

  fifo_status_prog #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .wr_data      (wr_data),
    .rd           (rd),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .af_level     (af_level),
    .ae_level     (ae_level),
    .w_count      (w_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  int          mcount = 0;
  bit          movf   = 1'b0;
  bit          mudf   = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic err_e enc_err(input logic o, input logic u);
    if (o === 1'b1) return ERR_OVF;
    if (u === 1'b1) return ERR_UDF;
    return ERR_NONE;
  endfunction

  // One clock of stimulus; the model advances with the DUT's edge.
  task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c, input bit rs);
    bit was_full, was_empty, wok, rok;
    was_full  = (mcount == DEPTH);
    was_empty = (mcount == 0);
    wok = w && !was_full && !rs;
    rok = r && !was_empty && !rs;
    wr = w; wr_data = d; rd = r; err_clr = c; rst = rs;
    if (rok) exp_q.push_back(model_q[0]);
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      mcount = 0;
      movf   = 1'b0;
      mudf   = 1'b0;
    end else begin
      if (rok) void'(model_q.pop_front());
      if (wok) model_q.push_back(d);
      mcount = mcount + int'(wok) - int'(rok);
      if (w && was_full) movf = 1'b1;
      else if (c)        movf = 1'b0;
      if (r && was_empty) mudf = 1'b1;
      else if (c)         mudf = 1'b0;
    end
    #1;
    wr = 1'b0; wr_data = '0; rd = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  // Monitor: data against the scoreboard, status against the occupancy model.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
`ifdef FIFO_STATUS_FWFT_EN
      check("rd_valid_fwft", rd_valid, 32'(mcount != 0));
      if (rd && rd_valid) begin
        if (exp_q.size() == 0) check("pop_without_expectation", rd_valid, 1'b0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end
`else
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_valid_without_read", rd_valid, 1'b0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end
`endif
      check("w_count", 32'(w_count), 32'(mcount));
      check("full", full, 32'(mcount == DEPTH));
      check("empty", empty, 32'(mcount == 0));
      check("almost_full", almost_full, 32'((af_level == 0) || (mcount >= int'(af_level))));
      check("almost_empty", almost_empty, 32'((int'(ae_level) >= DEPTH) || (mcount <= int'(ae_level))));
      check("err_flags", 32'(enc_err(overflow, underflow)), 32'(enc_err(movf, mudf)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; wr_data = '0;
    af_level = 5'd16; ae_level = 5'd2;

    step(0, 0, 0, 0, 1);
    step(1, 32'h99, 1, 0, 1);
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_w_count", 32'(w_count), 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_almost_full", almost_full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
`ifndef FIFO_STATUS_FWFT_EN
    check("rst_rd_data", rd_data, 0);
`endif
    #1;

    // Fill then drain
    for (int i = 1; i <= 16; i++) step(1, 32'(i), 0, 0, 0);
    @(negedge clk);
    check("fill_full", full, 1);
    check("fill_w_count", 32'(w_count), 16);
    #1;
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("drain_empty", empty, 1);
    check("drain_overflow", overflow, 0);
    check("drain_underflow", underflow, 0);
    #1;
    af_level = 5'd0;
    #1;
    check("af_zero_forces_almost_full", almost_full, 1);
    af_level = 5'd16;

    // Overflow with a simultaneous accepted read
    for (int i = 1; i <= 16; i++) step(1, 32'h100 + 32'(i), 0, 0, 0);
    step(1, 32'hDEAD, 1, 0, 0);
    @(negedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_w_count", 32'(w_count), 15);
    #1;
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    #1;
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Underflow with a simultaneous accepted write
    step(1, 32'h55, 1, 0, 0);
    @(negedge clk);
    check("udf_flag", underflow, 1);
    check("udf_w_count", 32'(w_count), 1);
    #1;
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("udf_cleared", underflow, 0);
    #1;

    // Thresholds
    af_level = 5'd12; ae_level = 5'd3;
    for (int i = 1; i <= 12; i++) begin
      step(1, 32'h200 + 32'(i), 0, 0, 0);
      @(negedge clk);
      check("thr_almost_empty", almost_empty, 32'(i <= 3));
      check("thr_almost_full", almost_full, 32'(i >= 12));
      #1;
    end
    step(1, 32'h20D, 0, 0, 0);
    @(negedge clk);
    check("thr13_almost_full_af12", almost_full, 1);
    #1;
    af_level = 5'd14;
    #1;
    check("thr13_almost_full_af14", almost_full, 0);
    for (int i = 14; i <= 16; i++) begin
      step(1, 32'h200 + 32'(i), 0, 0, 0);
      @(negedge clk);
      check("thr_almost_full_hi", almost_full, 1);
      #1;
    end
    ae_level = 5'd16;
    #1;
    check("ae_depth_forces_almost_empty", almost_empty, 1);
    ae_level = 5'd3;
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Wrap with continuous concurrent traffic at count 8
    af_level = 5'd16; ae_level = 5'd2;
    for (int i = 1; i <= 8; i++) step(1, 32'h300 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 32'h400 + 32'(i), 1, 0, 0);
    @(negedge clk);
    check("wrap_w_count", 32'(w_count), 8);
    #1;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset mid-stream
    for (int i = 1; i <= 9; i++) step(1, 32'h500 + 32'(i), 0, 0, 0);
    step(1, 32'h5AA, 0, 0, 1);
    @(negedge clk);
    check("mid_rst_w_count", 32'(w_count), 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_underflow", underflow, 0);
    #1;
    step(1, 32'h77, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
